// File: rtl/pacman_pkg.sv
// Shared types and default constants for the Pac-Man game controller.
package pacman_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } game_state_t;

  localparam int LIVES_INIT_DEF    = 3;
  localparam int READY_FRAMES_DEF  = 120;
  localparam int DEATH_FRAMES_DEF  = 90;
  localparam int GHOST_DIV_DEF     = 2;
  localparam int GHOST_DIV_MIN_DEF = 1;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// tick_divider: programmable divide-by-N of an input tick with synchronous clear.
// The divisor is sampled on clear and at each wrap, so a changed div only
// takes effect at the next period boundary.
module tick_divider #(
  parameter int RESET_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] div,
  output logic       pulse
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] div_q, div_d;

  // Next count / active divisor and the output pulse on the final tick of a period
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    pulse = 1'b0;
    if (clr) begin
      cnt_d = '0;
      div_d = div;
    end else if (tick) begin
      if (cnt_q == div_q - 8'd1) begin
        cnt_d = '0;
        div_d = div;
        pulse = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Counter and active-divisor registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= 8'(RESET_DIV);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-phase controller (IDLE/READY/PLAY/DYING/WIN/LOSE),
// frame tick from VGA vsync, lives counter and per-frame move enables.
// Optional feature macro: GHOST_SPEEDUP_EN (ghosts speed up every 32 pellets).
module game_sequencer
  import pacman_pkg::*;
#(
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int READY_FRAMES  = READY_FRAMES_DEF,
  parameter int DEATH_FRAMES  = DEATH_FRAMES_DEF,
  parameter int GHOST_DIV     = GHOST_DIV_DEF,
  parameter int GHOST_DIV_MIN = GHOST_DIV_MIN_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_vs,
  input  logic       start,
  input  logic       collision,
  input  logic       cleared,
  input  logic       pellet_eaten,
  output logic [2:0] state,
  output logic       frame_tick,
  output logic       pac_move_en,
  output logic       ghost_move_en,
  output logic       round_reset,
  output logic       freeze,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       win
);

  game_state_t state_q, state_d;
  logic        vs_prev_q, vs_prev_d;
  logic        frame_tick_q, frame_tick_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  lives_q, lives_d;
  logic        round_reset_q, round_reset_d;
  logic        freeze_q, freeze_d;
  logic        game_over_q, game_over_d;
  logic        win_q, win_d;
  logic [7:0]  div;
  logic        play_entry;
  logic        play_tick;
  logic        ghost_pulse;

  // Falling edge of vsync becomes a one-cycle frame tick
  always_comb begin
    vs_prev_d    = frame_vs;
    frame_tick_d = vs_prev_q & ~frame_vs;
  end

  // Vsync history and registered frame tick; history tracks vsync even in reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_prev_q    <= vs_prev_d;
      frame_tick_q <= 1'b0;
    end else begin
      vs_prev_q    <= vs_prev_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Phase sequencing, lives bookkeeping and registered status outputs
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    round_reset_d = 1'b0;
    frame_cnt_d   = frame_tick_q ? frame_cnt_q + 8'd1 : frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = READY;
          round_reset_d = 1'b1;
        end
      end
      READY: begin
        if (frame_tick_q && frame_cnt_q == 8'(READY_FRAMES - 1)) state_d = PLAY;
      end
      PLAY: begin
        if (collision)    state_d = DYING;
        else if (cleared) state_d = WIN;
      end
      DYING: begin
        if (frame_tick_q && frame_cnt_q == 8'(DEATH_FRAMES - 1)) begin
          if (lives_q > 2'd1) begin
            lives_d       = lives_q - 2'd1;
            round_reset_d = 1'b1;
            state_d       = READY;
          end else begin
            lives_d = '0;
            state_d = LOSE;
          end
        end
      end
      WIN, LOSE: ;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) frame_cnt_d = '0;
    freeze_d    = (state_d != PLAY);
    win_d       = (state_d == WIN);
    game_over_d = (state_d == LOSE);
  end

  // Phase state and registered outputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      lives_q       <= 2'(LIVES_INIT);
      round_reset_q <= 1'b0;
      freeze_q      <= 1'b1;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      lives_q       <= lives_d;
      round_reset_q <= round_reset_d;
      freeze_q      <= freeze_d;
      game_over_q   <= game_over_d;
      win_q         <= win_d;
    end
  end

  assign play_entry = (state_q != PLAY) && (state_d == PLAY);
  assign play_tick  = frame_tick_q && (state_q == PLAY);

`ifdef GHOST_SPEEDUP_EN
  logic [4:0] pellet_cnt_q, pellet_cnt_d;
  logic [7:0] div_q, div_d;

  // Every 32nd pellet eaten in PLAY lowers the ghost divisor down to its floor
  always_comb begin
    pellet_cnt_d = pellet_cnt_q;
    div_d        = div_q;
    if (pellet_eaten && state_q == PLAY) begin
      pellet_cnt_d = pellet_cnt_q + 5'd1;
      if (pellet_cnt_q == 5'd31 && div_q > 8'(GHOST_DIV_MIN)) div_d = div_q - 8'd1;
    end
  end

  // Pellet counter and requested divisor, restored only by reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pellet_cnt_q <= '0;
      div_q        <= 8'(GHOST_DIV);
    end else begin
      pellet_cnt_q <= pellet_cnt_d;
      div_q        <= div_d;
    end
  end

  assign div = div_q;
`else
  logic       unused_pellet_eaten;
  logic [7:0] unused_div_min;
  assign div                 = 8'(GHOST_DIV);
  assign unused_pellet_eaten = pellet_eaten;
  assign unused_div_min      = 8'(GHOST_DIV_MIN);
`endif

  tick_divider #(
    .RESET_DIV (GHOST_DIV)
  ) u_ghost_div (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (play_entry),
    .tick  (play_tick),
    .div   (div),
    .pulse (ghost_pulse)
  );

  assign state         = state_q;
  assign frame_tick    = frame_tick_q;
  assign pac_move_en   = play_tick;
  assign ghost_move_en = ghost_pulse;
  assign round_reset   = round_reset_q;
  assign freeze        = freeze_q;
  assign lives         = lives_q;
  assign game_over     = game_over_q;
  assign win           = win_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: randomized frame/event stimulus,
// a frame-level reference model, and a tick-driven scoreboard monitor.
`timescale 1ns/1ps
module tb_game_sequencer;

  localparam int RF   = 4;
  localparam int DF   = 3;
  localparam int LI   = 2;
  localparam int GMIN = 1;
`ifdef GHOST_SPEEDUP_EN
  localparam int GD      = 3;
  localparam bit SPEEDUP = 1'b1;
`else
  localparam int GD      = 2;
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_READY = 3'd1, S_PLAY = 3'd2,
                         S_DYING = 3'd3, S_WIN = 3'd4, S_LOSE = 3'd5;

  logic       Clk = 1'b0;
  logic       Reset_n, frame_vs, start, collision, cleared, pellet_eaten;
  logic [2:0] state;
  logic       frame_tick, pac_move_en, ghost_move_en, round_reset, freeze;
  logic [1:0] lives;
  logic       game_over, win;

  game_sequencer #(
    .LIVES_INIT    (LI),
    .READY_FRAMES  (RF),
    .DEATH_FRAMES  (DF),
    .GHOST_DIV     (GD),
    .GHOST_DIV_MIN (GMIN)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_vs      (frame_vs),
    .start         (start),
    .collision     (collision),
    .cleared       (cleared),
    .pellet_eaten  (pellet_eaten),
    .state         (state),
    .frame_tick    (frame_tick),
    .pac_move_en   (pac_move_en),
    .ghost_move_en (ghost_move_en),
    .round_reset   (round_reset),
    .freeze        (freeze),
    .lives         (lives),
    .game_over     (game_over),
    .win           (win)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: game phase advanced per frame and per event
  logic [2:0] m_state;
  int m_frames, m_lives, m_g, m_active, m_pending, m_pcount;
  int m_rr = 0, m_pac = 0, m_ghost = 0;
  int a_rr = 0, a_pac = 0, a_ghost = 0;

  typedef struct {
    logic [2:0] st;
    logic       pac;
    logic       ghost;
    logic       frz;
    logic [1:0] lv;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: each frame tick pops one expected record
  always @(negedge Clk) begin
    exp_t e;
    if (round_reset)   a_rr++;
    if (pac_move_en)   a_pac++;
    if (ghost_move_en) a_ghost++;
    if (pac_move_en || ghost_move_en) chk("move_needs_tick", frame_tick, 1);
    if (frame_tick) begin
      chk("tick_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tick_state", state, e.st);
        chk("tick_pac_en", pac_move_en, e.pac);
        chk("tick_ghost_en", ghost_move_en, e.ghost);
        chk("tick_freeze", freeze, e.frz);
        chk("tick_lives", lives, e.lv);
      end
    end
  end

  task automatic model_enter(input logic [2:0] s);
    m_state  = s;
    m_frames = 0;
    if (s == S_PLAY) begin
      m_g      = 0;
      m_active = m_pending;
    end
  endtask

  task automatic status(input string tag);
    chk({tag, "_state"}, state, m_state);
    chk({tag, "_lives"}, lives, m_lives);
    chk({tag, "_freeze"}, freeze, int'(m_state != S_PLAY));
    chk({tag, "_win"}, win, int'(m_state == S_WIN));
    chk({tag, "_game_over"}, game_over, int'(m_state == S_LOSE));
  endtask

  task automatic do_reset();
    @(posedge Clk); #1 Reset_n = 1'b0;
    start = 1'b0; collision = 1'b0; cleared = 1'b0; pellet_eaten = 1'b0;
    @(posedge Clk); #1;
    m_lives = LI; m_pending = GD; m_active = GD; m_pcount = 0; m_g = 0;
    model_enter(S_IDLE);
    status("reset");
    chk("reset_frame_tick", frame_tick, 0);
    chk("reset_pac_en", pac_move_en, 0);
    chk("reset_ghost_en", ghost_move_en, 0);
    chk("reset_round_reset", round_reset, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;
  endtask

  task automatic do_frame();
    exp_t e;
    e.st    = m_state;
    e.pac   = (m_state == S_PLAY);
    e.ghost = (m_state == S_PLAY) && (m_g == m_active - 1);
    e.frz   = (m_state != S_PLAY);
    e.lv    = 2'(m_lives);
    exp_q.push_back(e);
    if (e.pac)   m_pac++;
    if (e.ghost) m_ghost++;
    case (m_state)
      S_READY: begin
        m_frames++;
        if (m_frames == RF) model_enter(S_PLAY);
      end
      S_PLAY: begin
        if (e.ghost) begin
          m_g      = 0;
          m_active = m_pending;
        end else begin
          m_g++;
        end
      end
      S_DYING: begin
        m_frames++;
        if (m_frames == DF) begin
          if (m_lives > 1) begin
            m_lives--;
            m_rr++;
            model_enter(S_READY);
          end else begin
            m_lives = 0;
            model_enter(S_LOSE);
          end
        end
      end
      default: ;
    endcase
    @(posedge Clk); #1 frame_vs = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge Clk);
    #1 frame_vs = 1'b1;
    repeat ($urandom_range(3, 6)) @(posedge Clk);
    #1;
  endtask

  task automatic press_start();
    @(posedge Clk); #1 start = 1'b1;
    repeat ($urandom_range(1, 3)) @(posedge Clk);
    #1 start = 1'b0;
    if (m_state == S_IDLE) begin
      m_rr++;
      model_enter(S_READY);
    end
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic hit(input logic c, input logic cl);
    @(posedge Clk); #1 collision = c; cleared = cl;
    @(posedge Clk); #1 collision = 1'b0; cleared = 1'b0;
    if (m_state == S_PLAY) begin
      if (c)       model_enter(S_DYING);
      else if (cl) model_enter(S_WIN);
    end
    @(posedge Clk); #1;
  endtask

  task automatic pellet();
    @(posedge Clk); #1 pellet_eaten = 1'b1;
    @(posedge Clk); #1 pellet_eaten = 1'b0;
    if (SPEEDUP && m_state == S_PLAY) begin
      m_pcount++;
      if (m_pcount == 32) begin
        m_pcount = 0;
        if (m_pending > GMIN) m_pending--;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int g0;
    Reset_n = 1'b0; frame_vs = 1'b1; start = 1'b0; collision = 1'b0;
    cleared = 1'b0; pellet_eaten = 1'b0;
    repeat (3) @(posedge Clk);
    do_reset();

    // start, READY countdown, PLAY entry
    press_start();
    status("ready");
    chk("round_reset_on_start", a_rr, m_rr);
    repeat (RF) do_frame();
    status("play_entry");

    // steady PLAY: pacman every tick, ghosts every div ticks
    repeat (6) do_frame();
    chk("pac_total", a_pac, m_pac);
    chk("ghost_total", a_ghost, m_ghost);

    // lose a life, come back, lose the last one
    hit(1'b1, 1'b0);
    status("dying");
    repeat (DF) do_frame();
    status("back_to_ready");
    chk("round_reset_after_death", a_rr, m_rr);
    repeat (RF) do_frame();
    repeat ($urandom_range(1, 5)) do_frame();
    hit(1'b1, 1'b0);
    repeat (DF) do_frame();
    status("lose");
    press_start();
    repeat (2) do_frame();
    hit(1'b1, 1'b1);
    status("lose_held");

    // collision beats cleared; cleared alone wins
    do_reset();
    press_start();
    repeat (RF) do_frame();
    repeat ($urandom_range(0, 4)) do_frame();
    hit(1'b1, 1'b1);
    status("collision_priority");
    repeat (DF) do_frame();
    repeat (RF) do_frame();
    hit(1'b0, 1'b1);
    status("win");
    repeat (2) do_frame();
    hit(1'b1, 1'b0);
    press_start();
    status("win_held");

    // reset in the middle of the death animation
    do_reset();
    press_start();
    repeat (RF) do_frame();
    hit(1'b1, 1'b0);
    do_frame();
    do_reset();
    status("post_reset");

    // random play
    for (int r = 0; r < 4; r++) begin
      do_reset();
      press_start();
      for (int i = 0; i < 40; i++) begin
        int unsigned act;
        act = $urandom_range(0, 19);
        if (act < 13)       do_frame();
        else if (act < 15)  hit(1'b1, 1'b0);
        else if (act == 15) hit(1'b0, 1'b1);
        else if (act == 16) hit(1'b1, 1'b1);
        else if (act == 17) press_start();
        else                pellet();
        status("rand");
      end
    end

`ifdef GHOST_SPEEDUP_EN
    // ghost speedup down to the floor, then no further change
    do_reset();
    press_start();
    repeat (RF) do_frame();
    for (int i = 0; i < 64; i++) begin
      pellet();
      if (i % 4 == 3) do_frame();
    end
    repeat (3) do_frame();
    g0 = a_ghost;
    repeat (6) do_frame();
    chk("ghost_every_tick", a_ghost - g0, 6);
    for (int i = 0; i < 32; i++) pellet();
    repeat (2) do_frame();
    g0 = a_ghost;
    repeat (4) do_frame();
    chk("ghost_floor_held", a_ghost - g0, 4);
`else
    g0 = 0;
`endif

    @(posedge Clk); #1;
    chk("final_pac_total", a_pac, m_pac);
    chk("final_ghost_total", a_ghost, m_ghost);
    chk("final_round_reset_total", a_rr, m_rr);
    chk("final_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
